// File: rtl/z_product_serializer_pkg.sv
// Shared types and constants for the product serializer: FSM state encoding,
// default widths/depths and small sizing helpers.
package z_product_serializer_pkg;

  localparam int Z_DATA_W = 32;
  localparam int Z_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  // Pointer width is kept at least 1 so a single-entry FIFO still has a legal vector.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/product_fifo.sv
// Small product FIFO: circular storage with modulo-DEPTH pointers, occupancy count,
// full/empty flags and a synchronous flush that discards everything held.
module product_fifo
  import z_product_serializer_pkg::*;
#(
  parameter int W     = 2 * Z_DATA_W,
  parameter int DEPTH = Z_DEPTH,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clock,
  input  logic          clear_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/z_product_serializer.sv
// Serializes 2*DATA_W multiplier products onto a DATA_W bus as LO then HI words.
// Optional macro Z_OVF_FLAG_EN adds the ovf output (HI not a sign extension of LO).
module z_product_serializer
  import z_product_serializer_pkg::*;
#(
  parameter int DATA_W = Z_DATA_W,
  parameter int DEPTH  = Z_DEPTH
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic                p_valid,
  input  logic [2*DATA_W-1:0] p_data,
  output logic                p_ready,
  input  logic                flush,
  output logic                bus_valid,
  output logic [DATA_W-1:0]   bus_data,
  output logic                bus_hi,
  input  logic                bus_ready,
  output logic                busy
`ifdef Z_OVF_FLAG_EN
  ,
  output logic                ovf
`endif
);

  localparam int CW = cnt_w(DEPTH);

  state_t              state, state_nxt;
  logic [2*DATA_W-1:0] head;
  logic [CW-1:0]       count;
  logic                full, empty, push, pop;

  // p_ready comes from the registered count only, so a same-cycle pop never opens it.
  assign p_ready = !full;
  assign push    = p_valid && p_ready && !flush;
  assign pop     = bus_valid && bus_ready && (state == SEND_HI) && !flush;

  product_fifo #(.W(2 * DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .clear_n (clear_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (p_data),
    .rdata   (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_valid = 1'b0;
    bus_hi    = 1'b0;
    bus_data  = '0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = SEND_LO;
      end
      SEND_LO: begin
        bus_valid = 1'b1;
        bus_data  = head[DATA_W-1:0];
        if (bus_ready) state_nxt = SEND_HI;
      end
      SEND_HI: begin
        bus_valid = 1'b1;
        bus_hi    = 1'b1;
        bus_data  = head[2*DATA_W-1:DATA_W];
        // Stay busy without a bubble if anything remains once the head is popped.
        if (bus_ready) state_nxt = ((count > CW'(1)) || push) ? SEND_LO : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign busy = !empty || (state != IDLE);

`ifdef Z_OVF_FLAG_EN
  assign ovf = bus_valid && (head[2*DATA_W-1:DATA_W] != {DATA_W{head[DATA_W-1]}});
`endif

endmodule

// File: tb/tb_z_product_serializer.sv
// Directed bench for z_product_serializer with a queue-based word-stream model
// checked every cycle; define Z_OVF_FLAG_EN to also exercise the ovf output.
module tb_z_product_serializer;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic            clock = 1'b0;
  logic            clear_n = 1'b0;
  logic            p_valid = 1'b0;
  logic [2*DW-1:0] p_data = '0;
  logic            p_ready;
  logic            flush = 1'b0;
  logic            bus_valid;
  logic [DW-1:0]   bus_data;
  logic            bus_hi;
  logic            bus_ready = 1'b0;
  logic            busy;
`ifdef Z_OVF_FLAG_EN
  logic            ovf;
`endif

  z_product_serializer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .p_valid   (p_valid),
    .p_data    (p_data),
    .p_ready   (p_ready),
    .flush     (flush),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .bus_hi    (bus_hi),
    .bus_ready (bus_ready),
    .busy      (busy)
`ifdef Z_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clock = ~clock;

  // Model: the expected word stream plus the number of products not yet fully sent.
  typedef struct {
    logic [2*DW-1:0] prod;
    logic            hi;
  } word_t;

  word_t wq[$];
  int    cnt = 0;
  bit    fresh = 0;
  bit    exp_valid = 0;
  bit    m_hs, m_acc, m_hipop;
  int    m_c0;

  initial forever begin
    @(posedge clock or negedge clear_n);
    if (!clear_n) begin
      wq.delete();
      cnt = 0;
      fresh = 0;
      exp_valid = 0;
    end else begin
      m_c0  = cnt;
      m_hs  = exp_valid && bus_ready;
      m_acc = p_valid && (cnt < DEPTH) && !flush;
      if (flush) begin
        wq.delete();
        cnt = 0;
        fresh = 0;
      end else begin
        m_hipop = m_hs && wq[0].hi;
        if (m_hs) void'(wq.pop_front());
        if (m_acc) begin
          wq.push_back('{p_data, 1'b0});
          wq.push_back('{p_data, 1'b1});
        end
        cnt   = m_c0 - (m_hipop ? 1 : 0) + (m_acc ? 1 : 0);
        fresh = (m_c0 == 0) && m_acc;
      end
      exp_valid = (cnt > 0) && !fresh;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT to model on the falling edge, return just after the rising edge.
  task automatic cyc();
    @(negedge clock);
    chk("m_p_ready", p_ready, cnt < DEPTH);
    chk("m_busy", busy, cnt != 0);
    chk("m_bus_valid", bus_valid, exp_valid);
    if (exp_valid) begin
      chk("m_bus_data", bus_data, wq[0].hi ? wq[0].prod[2*DW-1:DW] : wq[0].prod[DW-1:0]);
      chk("m_bus_hi", bus_hi, wq[0].hi);
`ifdef Z_OVF_FLAG_EN
      chk("m_ovf", ovf, wq[0].prod[2*DW-1:DW] != {DW{wq[0].prod[DW-1]}});
`endif
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bus_valid"}, bus_valid, 0);
    chk({tag, "_bus_data"}, bus_data, 0);
    chk({tag, "_bus_hi"}, bus_hi, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_p_ready"}, p_ready, 1);
  endtask

  logic [DW-1:0] got_d [8];
  logic          got_h [8];
  logic [DW-1:0] exp_d [6];
  logic          exp_h [6];
  logic [2*DW-1:0] h [3];
  int n, c_at, idx, vrun;
  bit acc;

  initial begin
    #1;
    chk_reset_vals("rst");
    cyc(); cyc();
    clear_n = 1'b1;
    cyc();

    // Single product, bus always ready.
    bus_ready = 1'b1;
    p_valid = 1'b1; p_data = 64'h00000001_FFFFFFFE;
    cyc();
    p_valid = 1'b0;
    chk("single_lat_valid", bus_valid, 0);
    chk("single_lat_busy", busy, 1);
    cyc();
    chk("single_lo_valid", bus_valid, 1);
    chk("single_lo_data", bus_data, 32'hFFFFFFFE);
    chk("single_lo_hi", bus_hi, 0);
    cyc();
    chk("single_hi_data", bus_data, 32'h00000001);
    chk("single_hi_hi", bus_hi, 1);
    cyc();
    chk("single_idle_valid", bus_valid, 0);
    chk("single_idle_busy", busy, 0);

    // Backpressure during LO.
    bus_ready = 1'b0;
    p_valid = 1'b1; p_data = 64'h12345678_9ABCDEF0;
    cyc();
    p_valid = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("bp_lo_held", bus_data, 32'h9ABCDEF0);
      chk("bp_lo_hi", bus_hi, 0);
      cyc();
    end
    bus_ready = 1'b1;
    cyc();
    chk("bp_hi_data", bus_data, 32'h12345678);
    chk("bp_hi_hi", bus_hi, 1);
    cyc();
    chk("bp_idle", bus_valid, 0);

    // Full FIFO: third product waits for the first HI pop.
    bus_ready = 1'b0;
    p_valid = 1'b1; p_data = 64'hA1A1A1A1_A0A0A0A0;
    cyc();
    p_data = 64'hB1B1B1B1_B0B0B0B0;
    cyc();
    chk("full_p_ready", p_ready, 0);
    p_data = 64'hC1C1C1C1_C0C0C0C0;
    cyc();
    chk("full_p_ready_hold", p_ready, 0);
    chk("full_head_lo", bus_data, 32'hA0A0A0A0);
    bus_ready = 1'b1;
    n = 0; c_at = -1;
    for (int k = 0; k < 10; k++) begin
      if (bus_valid && bus_ready && n < 8) begin
        got_d[n] = bus_data; got_h[n] = bus_hi; n++;
      end
      acc = p_valid && p_ready;
      if (acc) c_at = n;
      cyc();
      if (acc) p_valid = 1'b0;
    end
    exp_d = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hB0B0B0B0, 32'hB1B1B1B1, 32'hC0C0C0C0, 32'hC1C1C1C1};
    exp_h = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    chk("full_word_count", n, 6);
    for (int k = 0; k < 6; k++) begin
      chk("full_order_data", got_d[k], exp_d[k]);
      chk("full_order_hi", got_h[k], exp_h[k]);
    end
    chk("full_c_accept_point", c_at, 3);

    // Back-to-back streaming: no bubble across three products.
    h = '{64'h11111111_10101010, 64'h22222222_20202020, 64'h33333333_30303030};
    idx = 0; vrun = 0;
    p_valid = 1'b1; p_data = h[0];
    for (int k = 0; k < 10; k++) begin
      acc = p_valid && p_ready;
      cyc();
      if (bus_valid) vrun++;
      if (acc) begin
        idx++;
        p_valid = (idx < 3);
        p_data  = h[idx % 3];
      end
    end
    p_valid = 1'b0;
    chk("stream_valid_cycles", vrun, 6);
    chk("stream_done_busy", busy, 0);

    // Flush in SEND_HI with a same-cycle push.
    p_valid = 1'b1; p_data = 64'h0E0E0E0E_E0E0E0E0;
    cyc();
    p_valid = 1'b0;
    cyc();
    cyc();
    chk("flush_pre_hi", bus_hi, 1);
    flush = 1'b1; p_valid = 1'b1; p_data = 64'h0F0F0F0F_F0F0F0F0;
    cyc();
    flush = 1'b0; p_valid = 1'b0;
    chk("flush_valid", bus_valid, 0);
    chk("flush_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("flush_no_emit", bus_valid, 0);
    end

    // Asynchronous reset mid-pair.
    p_valid = 1'b1; p_data = 64'h55555555_44444444;
    cyc();
    p_valid = 1'b0;
    cyc();
    cyc();
    chk("arst_pre_hi", bus_hi, 1);
    #2 clear_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    cyc();
    clear_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("arst_no_stale", bus_valid, 0);
    end

`ifdef Z_OVF_FLAG_EN
    p_valid = 1'b1; p_data = 64'hFFFFFFFF_80000000;
    cyc();
    p_data = 64'h00000000_80000000;
    cyc();
    p_valid = 1'b0;
    chk("ovf_a_lo", ovf, 0);
    cyc();
    chk("ovf_a_hi", ovf, 0);
    cyc();
    chk("ovf_b_lo", ovf, 1);
    cyc();
    chk("ovf_b_hi", ovf, 1);
    cyc();
    cyc();
`endif

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
